// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: per-stage hold/flush, PC redirect with a pending slot
// for redirects that collide with a busy fetch, and stall/redirect performance counters.
module pipe_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_jmp,
  input  logic             ex_jcc,
  input  logic             ex_jc,
  input  logic [XLEN-1:0]  ex_jump_addr,
  input  logic             id_ld_hazard,
  input  logic             if_busy,
  input  logic             mem_busy,
  input  logic             perf_clr,
  output logic             pc_hold,
  output logic             pc_load,
  output logic [XLEN-1:0]  pc_load_addr,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_hold,
  output logic             id_ex_flush,
  output logic             ex_mem_hold,
  output logic             redir_pend,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redir_cnt
);

  typedef enum logic {StRun, StRedir} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pend_q, pend_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  redir_q, redir_d;

  logic              jump_req;
  logic              redir_take;
  logic              pc_hold_c, pc_load_c;
  logic [XLEN-1:0]   pc_load_addr_c;
  logic              if_id_hold_c, if_id_flush_c;
  logic              id_ex_hold_c, id_ex_flush_c;
  logic              ex_mem_hold_c;

  assign jump_req = ex_valid & (ex_jmp | (ex_jcc & ex_jc));

  always_comb begin
    state_d        = state_q;
    pend_d         = pend_q;
    redir_take     = 1'b0;
    pc_hold_c      = 1'b0;
    pc_load_c      = 1'b0;
    pc_load_addr_c = '0;
    if_id_hold_c   = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_hold_c   = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_hold_c  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (mem_busy) begin
          // Whole pipe freezes; a jump in EX simply re-presents next cycle.
          pc_hold_c     = 1'b1;
          if_id_hold_c  = 1'b1;
          id_ex_hold_c  = 1'b1;
          ex_mem_hold_c = 1'b1;
        end else if (jump_req) begin
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
          redir_take    = 1'b1;
          if (if_busy) begin
            pc_hold_c = 1'b1;
            pend_d    = ex_jump_addr;
            state_d   = StRedir;
          end else begin
            pc_load_c      = 1'b1;
            pc_load_addr_c = ex_jump_addr;
          end
        end else if (id_ld_hazard) begin
          pc_hold_c     = 1'b1;
          if_id_hold_c  = 1'b1;
          id_ex_flush_c = 1'b1;
        end else if (if_busy) begin
          pc_hold_c     = 1'b1;
          if_id_flush_c = 1'b1;
        end
      end
      StRedir: begin
        // Any fetch data arriving here belongs to the wrong path.
        if_id_flush_c = 1'b1;
        if (mem_busy) begin
          id_ex_hold_c  = 1'b1;
          ex_mem_hold_c = 1'b1;
        end
        if (if_busy) begin
          pc_hold_c = 1'b1;
        end else begin
          pc_load_c      = 1'b1;
          pc_load_addr_c = pend_q;
          state_d        = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Outputs are forced quiet while reset is asserted, independent of inputs.
  assign pc_hold      = rst_n & pc_hold_c;
  assign pc_load      = rst_n & pc_load_c;
  assign pc_load_addr = rst_n ? pc_load_addr_c : '0;
  assign if_id_hold   = rst_n & if_id_hold_c;
  assign if_id_flush  = rst_n & if_id_flush_c;
  assign id_ex_hold   = rst_n & id_ex_hold_c;
  assign id_ex_flush  = rst_n & id_ex_flush_c;
  assign ex_mem_hold  = rst_n & ex_mem_hold_c;
  assign redir_pend   = rst_n & (state_q == StRedir);

  always_comb begin
    stall_d = stall_q + {{(CNT_W-1){1'b0}}, pc_hold};
    redir_d = redir_q + {{(CNT_W-1){1'b0}}, redir_take};
    if (perf_clr) begin
      stall_d = '0;
      redir_d = '0;
    end
  end

  assign stall_cnt = stall_q;
  assign redir_cnt = redir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      pend_q  <= '0;
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      stall_q <= stall_d;
      redir_q <= redir_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed literal checks plus randomized traffic compared every cycle
// against a rule-level model. Counters are narrowed to 8 bits so wrap is reachable.
module tb_pipe_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ex_valid, ex_jmp, ex_jcc, ex_jc;
  logic [XLEN-1:0]  ex_jump_addr;
  logic             id_ld_hazard, if_busy, mem_busy, perf_clr;
  logic             pc_hold, pc_load, if_id_hold, if_id_flush;
  logic             id_ex_hold, id_ex_flush, ex_mem_hold, redir_pend;
  logic [XLEN-1:0]  pc_load_addr;
  logic [CNT_W-1:0] stall_cnt, redir_cnt;

  int n_vec  = 0;
  int n_fail = 0;
  bit run_cmp = 1'b0;

  pipe_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_jmp       (ex_jmp),
    .ex_jcc       (ex_jcc),
    .ex_jc        (ex_jc),
    .ex_jump_addr (ex_jump_addr),
    .id_ld_hazard (id_ld_hazard),
    .if_busy      (if_busy),
    .mem_busy     (mem_busy),
    .perf_clr     (perf_clr),
    .pc_hold      (pc_hold),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .if_id_hold   (if_id_hold),
    .if_id_flush  (if_id_flush),
    .id_ex_hold   (id_ex_hold),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_hold  (ex_mem_hold),
    .redir_pend   (redir_pend),
    .stall_cnt    (stall_cnt),
    .redir_cnt    (redir_cnt)
  );

  always #5 clk = ~clk;

  // {pc_hold, pc_load, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, redir_pend}
  logic [7:0] ctrl;
  assign ctrl = {pc_hold, pc_load, if_id_hold, if_id_flush,
                 id_ex_hold, id_ex_flush, ex_mem_hold, redir_pend};

  // Model state: whether a redirect is waiting on fetch, its target, and the two counts.
  bit              m_redir;
  logic [XLEN-1:0] m_pend;
  logic [CNT_W-1:0] m_stall, m_rcnt;

  function automatic logic jreq();
    return ex_valid && (ex_jmp || (ex_jcc && ex_jc));
  endfunction

  function automatic logic [7:0] exp_ctrl();
    logic [7:0] c;
    c = '0;
    if (!rst_n) return c;
    if (m_redir) begin
      c[0] = 1'b1;
      c[4] = 1'b1;
      if (if_busy) c[7] = 1'b1;
      else c[6] = 1'b1;
      if (mem_busy) begin
        c[3] = 1'b1;
        c[1] = 1'b1;
      end
    end else if (mem_busy) begin
      c = 8'b1010_1010;
    end else if (jreq()) begin
      c[4] = 1'b1;
      c[2] = 1'b1;
      if (if_busy) c[7] = 1'b1;
      else c[6] = 1'b1;
    end else if (id_ld_hazard) begin
      c = 8'b1010_0100;
    end else if (if_busy) begin
      c = 8'b1001_0000;
    end
    return c;
  endfunction

  function automatic logic [XLEN-1:0] exp_addr();
    if (!rst_n) return '0;
    if (m_redir && !if_busy) return m_pend;
    if (!m_redir && !mem_busy && jreq() && !if_busy) return ex_jump_addr;
    return '0;
  endfunction

  function automatic logic accept_now();
    return rst_n && !m_redir && !mem_busy && jreq();
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_redir <= 1'b0;
      m_pend  <= '0;
      m_stall <= '0;
      m_rcnt  <= '0;
    end else begin
      m_stall <= perf_clr ? '0 : m_stall + CNT_W'(exp_ctrl() >> 7);
      m_rcnt  <= perf_clr ? '0 : m_rcnt + CNT_W'(accept_now());
      if (!m_redir) begin
        if (accept_now() && if_busy) begin
          m_redir <= 1'b1;
          m_pend  <= ex_jump_addr;
        end
      end else if (!if_busy) begin
        m_redir <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      n_vec = n_vec + 1;
      if (ctrl !== exp_ctrl() || pc_load_addr !== exp_addr() ||
          stall_cnt !== m_stall || redir_cnt !== m_rcnt ||
          (pc_hold && pc_load) || (if_id_hold && if_id_flush) ||
          (id_ex_hold && id_ex_flush)) begin
        n_fail = n_fail + 1;
        $display("FAIL model t=%0t: ctrl=%b addr=%h stall=%0d redir=%0d, expected ctrl=%b addr=%h stall=%0d redir=%0d",
                 $time, ctrl, pc_load_addr, stall_cnt, redir_cnt,
                 exp_ctrl(), exp_addr(), m_stall, m_rcnt);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 0; ex_jmp = 0; ex_jcc = 0; ex_jc = 0; ex_jump_addr = '0;
    id_ld_hazard = 0; if_busy = 0; mem_busy = 0; perf_clr = 0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    // Outputs stay quiet in reset even with a jump presented.
    ex_valid = 1; ex_jmp = 1; ex_jump_addr = 32'h1234; if_busy = 1;
    #2;
    chk("reset_ctrl", {24'd0, ctrl}, 32'h0);
    chk("reset_addr", pc_load_addr, 32'h0);
    chk("reset_cnt", {stall_cnt, redir_cnt}, 32'h0);
    tick();
    idle();
    tick();
    rst_n = 1'b1;
    run_cmp = 1'b1;

    // Taken branch, fetch idle.
    ex_valid = 1; ex_jcc = 1; ex_jc = 1; ex_jump_addr = 32'h100;
    #2;
    chk("br_taken_ctrl", {24'd0, ctrl}, 32'b0101_0100);
    chk("br_taken_addr", pc_load_addr, 32'h100);
    tick();
    chk("br_taken_cnt", redir_cnt, 1);
    chk("br_taken_state", redir_pend, 0);

    // Not-taken branch.
    ex_jc = 0;
    #2;
    chk("br_nt_ctrl", {24'd0, ctrl}, 0);
    tick();
    chk("br_nt_cnt", redir_cnt, 1);

    // JAL during busy fetch for three cycles.
    idle();
    ex_valid = 1; ex_jmp = 1; ex_jump_addr = 32'h2000; if_busy = 1;
    #2;
    chk("jal_busy_c0", {24'd0, ctrl}, 32'b1001_0100);
    tick();
    ex_valid = 0; ex_jmp = 0;
    #2;
    chk("jal_busy_c1", {24'd0, ctrl}, 32'b1001_0001);
    tick();
    chk("jal_busy_c2", {24'd0, ctrl}, 32'b1001_0001);
    tick();
    if_busy = 0;
    #2;
    chk("jal_exit_ctrl", {24'd0, ctrl}, 32'b0101_0001);
    chk("jal_exit_addr", pc_load_addr, 32'h2000);
    tick();
    chk("jal_exit_state", redir_pend, 0);
    chk("jal_stall", stall_cnt, 3);
    chk("jal_redir", redir_cnt, 2);

    // Jump under mem_busy for two cycles.
    ex_valid = 1; ex_jmp = 1; ex_jump_addr = 32'h3000; mem_busy = 1;
    #2;
    chk("jmp_mem_c0", {24'd0, ctrl}, 32'b1010_1010);
    tick();
    chk("jmp_mem_c1", {24'd0, ctrl}, 32'b1010_1010);
    tick();
    mem_busy = 0;
    #2;
    chk("jmp_mem_load", {pc_load, pc_load_addr[30:0]}, {1'b1, 31'h3000});
    tick();
    chk("jmp_mem_redir", redir_cnt, 3);
    chk("jmp_mem_stall", stall_cnt, 5);

    // Load-use hazard.
    idle();
    id_ld_hazard = 1;
    #2;
    chk("ld_use_ctrl", {24'd0, ctrl}, 32'b1010_0100);
    tick();
    chk("ld_use_stall", stall_cnt, 6);

    // perf_clr beats a concurrent stall.
    perf_clr = 1;
    tick();
    chk("clr_stall", stall_cnt, 0);
    chk("clr_redir", redir_cnt, 0);
    idle();

    // Counter wrap at 2^CNT_W.
    if_busy = 1;
    for (int i = 0; i < 255; i++) tick();
    chk("stall_full", stall_cnt, 8'hFF);
    tick();
    chk("stall_wrap", stall_cnt, 0);
    idle();
    tick();

    // Reset while a redirect is pending.
    ex_valid = 1; ex_jmp = 1; ex_jump_addr = 32'h4000; if_busy = 1;
    tick();
    ex_valid = 0; ex_jmp = 0;
    #2;
    chk("pre_rst_pend", redir_pend, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_redir_ctrl", {24'd0, ctrl}, 0);
    chk("rst_redir_cnt", {stall_cnt, redir_cnt}, 0);
    tick();
    rst_n = 1'b1;
    if_busy = 0;
    #2;
    chk("post_rst_ctrl", {24'd0, ctrl}, 0);
    tick();

    // Randomized traffic; EX only carries bubbles while a redirect is pending.
    for (int i = 0; i < 3000; i++) begin
      rst_n        = ($urandom_range(0, 299) != 0);
      mem_busy     = ($urandom_range(0, 3) == 0);
      if_busy      = ($urandom_range(0, 2) == 0);
      id_ld_hazard = ($urandom_range(0, 5) == 0);
      perf_clr     = ($urandom_range(0, 79) == 0);
      ex_valid     = m_redir ? 1'b0 : 1'($urandom_range(0, 1));
      ex_jmp       = ($urandom_range(0, 3) == 0);
      ex_jcc       = 1'($urandom_range(0, 1));
      ex_jc        = 1'($urandom_range(0, 1));
      ex_jump_addr = $urandom;
      tick();
    end
    rst_n = 1'b1;
    idle();
    tick();
    run_cmp = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
